// File: rtl/gP.sv
// Shared types and default geometry for the datapath data memory.
package gP;
   localparam int width   = 16;
   localparam int rowData = 8;

   typedef enum logic {DM_SCRUB, DM_IDLE} dm_state_t;
endpackage

// File: rtl/dat_mem_array.sv
// WIDTH x DEPTH word store with a byte-lane write port and a registered read port.
module dat_mem_array
   import gP::*;
#(
   parameter int WIDTH = width,
   parameter int DEPTH = rowData,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int NB    = WIDTH / 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [NB-1:0]    be_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] raddr_i,
   input  logic             rzero_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: storage has no reset so it maps onto RAM; the controller's scrub gives it a known start.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < NB; i++) begin
            if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Read-first: a same-edge write to this index lands after the old word is captured.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dat_mem_bank_ctrl.sv
// Data memory controller: scrub FSM, range check, request gating and read/error strobes.
module dat_mem_bank_ctrl
   import gP::*;
#(
   parameter int WIDTH  = width,
   parameter int DEPTH  = rowData,
   parameter int ADDR_W = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [ADDR_W-1:0]    ADDR,
   input  logic [WIDTH-1:0]     WriteDat,
   input  logic [WIDTH/8-1:0]   BE,
   input  logic                 WEN,
   input  logic                 REN,
   input  logic                 CLR,
   output logic [WIDTH-1:0]     ReadDat,
   output logic                 RVALID,
   output logic                 ERR,
   output logic                 BUSY
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = WIDTH / 8;

   dm_state_t        state_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q;
   logic             rvalid_q;
   logic             err_q;

   logic             idle;
   logic             in_range;
   logic             req_ok;
   logic             wr_acc;
   logic             rd_acc;
   logic [IDX_W-1:0] req_idx;

   assign idle     = (state_q == DM_IDLE);
   assign in_range = (ADDR < ADDR_W'(DEPTH));
   assign req_idx  = ADDR[IDX_W-1:0];
   // CLR takes priority over any load/store presented in the same cycle.
   assign req_ok   = idle && !CLR;
   assign wr_acc   = req_ok && WEN && in_range;
   assign rd_acc   = req_ok && REN;

   // NOTE: every state register updates with <= so all flops see the pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= DM_SCRUB;
         idx_q    <= '0;
         busy_q   <= 1'b1;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= rd_acc;
         err_q    <= req_ok && (WEN || REN) && !in_range;
         case (state_q)
            DM_SCRUB: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_W'(DEPTH - 1)) begin
                  state_q <= DM_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DM_IDLE: begin
               if (CLR) begin
                  state_q <= DM_SCRUB;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= DM_SCRUB;
               idx_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   dat_mem_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (CLK),
      .rst_i   (RST),
      .we_i    (!idle || wr_acc),
      .waddr_i (idle ? req_idx : idx_q),
      .wdata_i (idle ? WriteDat : '0),
      .be_i    (idle ? BE : {NB{1'b1}}),
      .re_i    (rd_acc),
      .raddr_i (req_idx),
      .rzero_i (!in_range),
      .rdata_o (ReadDat)
   );

   assign RVALID = rvalid_q;
   assign ERR    = err_q;
   assign BUSY   = busy_q;

endmodule
